// File: rtl/ballot_collector.sv
// Ballot collector: gathers one locked yes/no vote per voter per session and presents the vote vector.
// Latency: a press sampled at edge k is visible after edge k; votes_valid rises on the edge that latches the last vote.
// Backpressure: the result is held in DONE until votes_ack; start is only honoured in IDLE. Optional timer via BALLOT_TIMEOUT_EN.
module ballot_collector #(
    parameter int PERSON  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [PERSON-1:0]           yes_btn,
    input  logic [PERSON-1:0]           no_btn,
    input  logic                        votes_ack,
    output logic [PERSON-1:0]           votes,
    output logic [PERSON-1:0]           voted,
    output logic [$clog2(PERSON+1)-1:0] yes_count,
    output logic                        votes_valid,
    output logic                        busy,
    output logic                        timed_out
);

    localparam int CW = $clog2(PERSON + 1);

    // Reject nonsensical configurations at elaboration time.
    if (PERSON < 1 || TIMEOUT < 2) begin : g_param_check
        $error("ballot_collector: PERSON must be >= 1 and TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PERSON-1:0]   r_votes;
    logic [PERSON-1:0]   r_voted;
    logic [CW-1:0]       r_yes_count;
    logic [PERSON-1:0]   w_press;
    logic [PERSON-1:0]   w_votes_nxt;
    logic [PERSON-1:0]   w_voted_nxt;
    logic [CW-1:0]       w_yes_cnt_nxt;
    logic                w_all_voted;
    logic                w_timeout_hit;

`ifdef BALLOT_TIMEOUT_EN
    localparam int          TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_TOP = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_timer;
    logic          r_timed_out;
`endif

    // Per-voter acceptance: only unvoted voters with exactly one button pressed are latched.
    always_comb begin
        w_press     = ~r_voted & (yes_btn ^ no_btn);
        w_votes_nxt = r_votes | (w_press & yes_btn);
        w_voted_nxt = r_voted | w_press;
        w_all_voted = &w_voted_nxt;
    end

    // Popcount of the vote vector about to be registered, so yes_count tracks votes exactly.
    always_comb begin
        w_yes_cnt_nxt = '0;
        for (int i = 0; i < PERSON; i++) begin
            w_yes_cnt_nxt = w_yes_cnt_nxt + CW'(w_votes_nxt[i]);
        end
    end

    // Timeout fires on the last permitted OPEN cycle only if that cycle's presses leave someone unvoted.
`ifdef BALLOT_TIMEOUT_EN
    always_comb begin
        w_timeout_hit = (r_timer == T_TOP) && !w_all_voted;
    end
`else
    always_comb begin
        w_timeout_hit = 1'b0;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; completion and timeout both leave OPEN on the same edge that samples the presses.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)                        w_state_nxt = ST_OPEN;
            ST_OPEN: if (w_all_voted || w_timeout_hit) w_state_nxt = ST_DONE;
            ST_DONE: if (votes_ack)                    w_state_nxt = ST_IDLE;
            default:                                   w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state only.
    always_comb begin
        votes_valid = (r_state == ST_DONE);
        busy        = (r_state == ST_OPEN);
    end

    // Vote datapath: cleared on start, updated while OPEN, frozen in DONE and kept through IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_votes     <= '0;
            r_voted     <= '0;
            r_yes_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_votes     <= '0;
                        r_voted     <= '0;
                        r_yes_count <= '0;
                    end
                end
                ST_OPEN: begin
                    r_votes     <= w_votes_nxt;
                    r_voted     <= w_voted_nxt;
                    r_yes_count <= w_yes_cnt_nxt;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BALLOT_TIMEOUT_EN
    // Session timer counts OPEN cycles from 0; timed_out records why the session closed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_timer     <= '0;
            r_timed_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_timer     <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                ST_OPEN: begin
                    if (r_timer != T_TOP) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    r_timed_out <= w_timeout_hit;
                end
                default: begin
                end
            endcase
        end
    end

    // Timed-out flag drives straight from its register.
    always_comb begin
        timed_out = r_timed_out;
    end
`else
    // Without the timer a session can only end by full participation.
    always_comb begin
        timed_out = 1'b0;
    end
`endif

    // Vote outputs drive straight from their registers.
    always_comb begin
        votes     = r_votes;
        voted     = r_voted;
        yes_count = r_yes_count;
    end

endmodule

// File: tb/tb_ballot_collector.sv
module tb_ballot_collector;

    localparam int PERSON  = 3;
    localparam int TIMEOUT = 8;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] yes_btn;
    logic [2:0] no_btn;
    logic       votes_ack;
    logic [2:0] votes;
    logic [2:0] voted;
    logic [1:0] yes_count;
    logic       votes_valid;
    logic       busy;
    logic       timed_out;

    ballot_collector #(.PERSON(PERSON), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .yes_btn     (yes_btn),
        .no_btn      (no_btn),
        .votes_ack   (votes_ack),
        .votes       (votes),
        .voted       (voted),
        .yes_count   (yes_count),
        .votes_valid (votes_valid),
        .busy        (busy),
        .timed_out   (timed_out)
    );

    typedef struct {
        logic [2:0] votes;
        logic [2:0] voted;
        logic [1:0] cnt;
        logic       tout;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising votes_valid must match the oldest expected result.
    always @(negedge clk) begin
        if (votes_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: votes_valid rose with no result expected (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_votes", 32'(votes), 32'(e.votes));
                chk("sb_voted", 32'(voted), 32'(e.voted));
                chk("sb_yes_count", 32'(yes_count), 32'(e.cnt));
                chk("sb_timed_out", 32'(timed_out), 32'(e.tout));
                chk("sb_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_valid = votes_valid;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [2:0] v, input logic [2:0] vd, input logic [1:0] c,
                        input logic t, input int at);
        exp_t e;
        e.votes = v; e.voted = vd; e.cnt = c; e.tout = t; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic open_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!votes_valid && n < budget) begin
            tick();
            n++;
        end
        if (!votes_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: votes_valid still %0b after %0d cycles, expected 1", votes_valid, budget);
        end
    endtask

    task automatic ack();
        votes_ack = 1'b1;
        tick();
        votes_ack = 1'b0;
        chk("valid_after_ack", 32'(votes_valid), 32'd0);
        chk("busy_after_ack", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; yes_btn = '0; no_btn = '0; votes_ack = 1'b0;
        tick(); tick();
        chk("rst_votes", 32'(votes), 32'd0);
        chk("rst_voted", 32'(voted), 32'd0);
        chk("rst_yes_count", 32'(yes_count), 32'd0);
        chk("rst_valid", 32'(votes_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timed_out", 32'(timed_out), 32'd0);
        reset = 1'b1;
        // Buttons and ack in IDLE are ignored.
        yes_btn = 3'b111; votes_ack = 1'b1;
        tick();
        yes_btn = '0; votes_ack = 1'b0;
        chk("idle_ignores_btn", 32'(voted), 32'd0);
        chk("idle_stays_idle", 32'(busy), 32'd0);

        // Separate-cycle votes: 0 yes, 1 yes, 2 no.
        open_session();
        yes_btn = 3'b001; tick();
        chk("t1_voted_p0", 32'(voted), 32'b001);
        yes_btn = 3'b010; tick();
        chk("t1_votes_p1", 32'(votes), 32'b011);
        chk("t1_valid_early", 32'(votes_valid), 32'd0);
        yes_btn = 3'b000; no_btn = 3'b100;
        push(3'b011, 3'b111, 2'd2, 1'b0, cyc + 1);
        tick();
        no_btn = '0;
        ack();
        chk("t1_votes_kept_idle", 32'(votes), 32'b011);

        // Locking after first press, and both-buttons ignored.
        open_session();
        no_btn = 3'b010; tick();
        no_btn = '0;
        chk("t2_voted_p1", 32'(voted), 32'b010);
        yes_btn = 3'b010; tick();
        chk("t2_lock_p1", 32'(votes), 32'b000);
        yes_btn = 3'b001; no_btn = 3'b001;
        tick(); tick(); tick();
        chk("t2_both_ignored", 32'(voted), 32'b010);
        no_btn = '0; tick();
        yes_btn = '0;
        chk("t2_single_latched", 32'(votes), 32'b001);
        chk("t2_voted_p0", 32'(voted), 32'b011);
        no_btn = 3'b100;
        push(3'b001, 3'b111, 2'd1, 1'b0, cyc + 1);
        tick();
        no_btn = '0;
        ack();

        // Simultaneous votes, then start in DONE is ignored.
        open_session();
        yes_btn = 3'b111;
        push(3'b111, 3'b111, 2'd3, 1'b0, cyc + 1);
        tick();
        yes_btn = '0;
        start = 1'b1; tick(); start = 1'b0;
        chk("t3_start_in_done_valid", 32'(votes_valid), 32'd1);
        chk("t3_start_in_done_busy", 32'(busy), 32'd0);
        chk("t3_votes_stable", 32'(votes), 32'b111);
        tick();
        chk("t3_votes_stable2", 32'(yes_count), 32'd3);
        ack();

        // Reset mid-session aborts it.
        open_session();
        no_btn = 3'b010; tick(); no_btn = '0;
        chk("t4_voted_pre", 32'(voted), 32'b010);
        reset = 1'b0; tick(); reset = 1'b1;
        chk("t4_rst_voted", 32'(voted), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_valid", 32'(votes_valid), 32'd0);

`ifdef BALLOT_TIMEOUT_EN
        // Timeout with only voter 2 voting: closes at the 8th OPEN edge.
        open_session();
        push(3'b100, 3'b100, 2'd1, 1'b1, cyc + TIMEOUT);
        yes_btn = 3'b100; tick(); yes_btn = '0;
        wait_valid(20);
        ack();
        // Completing the vote in the final cycle keeps timed_out low.
        open_session();
        yes_btn = 3'b100; tick(); yes_btn = '0;
        for (int i = 0; i < TIMEOUT - 2; i++) tick();
        chk("t5_still_open", 32'(busy), 32'd1);
        yes_btn = 3'b011;
        push(3'b111, 3'b111, 2'd3, 1'b0, cyc + 1);
        tick(); yes_btn = '0;
        wait_valid(4);
        ack();
`else
        // Without the timer the session waits indefinitely.
        open_session();
        yes_btn = 3'b100; tick(); yes_btn = '0;
        for (int i = 0; i < 300; i++) tick();
        chk("t5_no_timeout_busy", 32'(busy), 32'd1);
        chk("t5_no_timeout_flag", 32'(timed_out), 32'd0);
        no_btn = 3'b011;
        push(3'b100, 3'b111, 2'd1, 1'b0, cyc + 1);
        tick(); no_btn = '0;
        wait_valid(4);
        ack();
`endif

        tick();
        chk("sb_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ballot_collector.md
# ballot_collector

- Sequential front end that gathers one yes/no ballot per voter over a voting session.
- Presents the completed vote vector, with a valid/ack handshake, to the downstream majority-decision logic.
- Each voter may vote once per session. Presses are locked after the first one.
- The session closes when all voters have voted or, optionally, when a timeout expires. Unvoted voters count as "no".

## Interface
- PERSON, 3, number of voters (≥1)
- TIMEOUT, 255, session length limit in clock cycles (≥2); used only with timeout compiled in
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low
- start  input  1  opens a session; sampled only in IDLE
- yes_btn  input  PERSON  per-voter "yes" level
- no_btn  input  PERSON  per-voter "no" level
- votes_ack  input  1  consumer accepts the result; sampled only in DONE
- votes  output  PERSON  vote vector, 1 = yes
- voted  output  PERSON  per-voter "has voted" flags
- yes_count  output  $clog2(PERSON+1)  number of yes votes in `votes`
- votes_valid  output  1  result is stable and valid (DONE state)
- busy  output  1  session open (OPEN state)
- timed_out  output  1  session closed by timeout

## Operation
- Reset (reset==0 at a clock edge):
  - State becomes IDLE.
  - votes, voted, yes_count, votes_valid, busy, timed_out and the timer are all cleared to 0.
  - Reset overrides everything and aborts any session in progress.
- States: IDLE, OPEN, DONE. votes_valid is 1 in DONE only; busy is 1 in OPEN only.
- IDLE:
  - votes_ack and all buttons are ignored.
  - start==1 → OPEN. The same edge clears votes, voted, yes_count, timed_out and the timer.
- OPEN, per voter i with voted[i]==0:
  - yes_btn[i]=1 and no_btn[i]=0 → votes[i]=1, voted[i]=1.
  - no_btn[i]=1 and yes_btn[i]=0 → votes[i]=0, voted[i]=1.
  - Both buttons high → ignored that cycle; the voter may vote later.
  - Once voted[i]==1, further presses from voter i are ignored.
  - Several voters may vote in the same cycle.
- yes_count always equals the popcount of the registered `votes`.
- OPEN → DONE when the next value of voted is all ones. This transition happens on the same edge that latches the last vote.
- Timeout: OPEN → DONE with timed_out=1 when the timer reaches TIMEOUT-1 and the voters are still not all voted after that edge.
  - Votes pressed in that final cycle are still registered.
  - If the final cycle's presses complete the vote, timed_out stays 0.
  - Unvoted voters keep votes[i]=0 and voted[i]=0.
- start is ignored in OPEN and in DONE.
- DONE:
  - votes, voted, yes_count and timed_out are held stable.
  - votes_ack==1 → IDLE. The outputs keep their values until the next start.

## Timing
- start sampled at edge n → busy=1 after edge n. Buttons are sampled from edge n+1 onward.
- A press sampled at edge k → votes[i] and voted[i] updated after edge k.
- Last vote latched at edge k → votes_valid=1 after edge k (zero added latency).
- With timeout, OPEN lasts at most TIMEOUT cycles. The timer counts OPEN cycles 0..TIMEOUT-1 and has width $clog2(TIMEOUT).
- votes_ack sampled at edge m in DONE → votes_valid=0 and state IDLE after edge m.
- start at the same edge that returns to IDLE is not seen. start must be sampled in IDLE.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- BALLOT_TIMEOUT_EN defined:
  - Timer and timeout transition are present.
  - timed_out behaves as described above.
- BALLOT_TIMEOUT_EN undefined:
  - No timer logic; TIMEOUT is unused.
  - OPEN is left only when all voters have voted, and the session may wait indefinitely.
  - timed_out is tied to 0.

## Test plan
- PERSON=3, reset low 2 cycles then high → all outputs 0, state IDLE. Start, then voters 0,1 yes and voter 2 no in separate cycles → votes=3'b011, voted=3'b111, yes_count=2, votes_valid=1 the cycle after the third press. Ack → IDLE.
- Voter 1 presses no, then later yes → votes[1] stays 0. Voter 0 holds both buttons 3 cycles, then yes only → votes[0]=1, latched on the first single-button cycle.
- All three voters press yes in the same cycle → votes=3'b111, yes_count=3, votes_valid asserted after that single edge.
- With BALLOT_TIMEOUT_EN and TIMEOUT=8, only voter 2 votes yes → after 8 OPEN cycles: votes_valid=1, timed_out=1, voted=3'b100, votes=3'b100. The same scenario with the last two votes pressed in cycle 8 → timed_out=0.
- reset driven low mid-OPEN with voted=3'b010 → next cycle all outputs 0, IDLE. start pulsed in DONE is ignored, and votes stay stable until ack.
